// File: rtl/min_frame_loader_pkg.sv
// Shared types and sizes for the min_finder frame loader.
// Frame geometry matches the ten 4-bit inputs of min_finder.
package min_pkg;

    localparam int N_NUMBER = 10;
    localparam int N_BIT    = 4;
    localparam int CNT_W    = 4;

    typedef logic [N_BIT-1:0] sample_t;
    typedef sample_t [N_NUMBER-1:0] frame_t;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL
    } bank_state_e;

endpackage

// File: rtl/min_frame_loader_bank.sv
// One frame-sized register bank, written one sample at a time.
// The whole bank is visible in parallel as a flattened frame.
module frame_bank
    import min_pkg::*;
#(
    parameter int NUM  = min_pkg::N_NUMBER,
    parameter int BITS = min_pkg::N_BIT
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                we_i,
    input  logic [CNT_W-1:0]    idx_i,
    input  logic [BITS-1:0]     data_i,
    output logic [NUM*BITS-1:0] frame_o
);

    logic [BITS-1:0] mem [NUM];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM; k++) begin
                mem[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM; k++) begin
                if (we_i && idx_i == CNT_W'(k)) begin
                    mem[k] <= data_i;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM; g++) begin : g_flat
        assign frame_o[g*BITS +: BITS] = mem[g];
    end

endmodule

// File: rtl/min_frame_loader.sv
// Ping-pong frame loader: serial samples in, whole frames out.
// One bank fills while the other is presented to the consumer.
module min_frame_loader
    import min_pkg::*;
#(
    parameter int NUM  = min_pkg::N_NUMBER,
    parameter int BITS = min_pkg::N_BIT
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [BITS-1:0]     data_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic                flush_i,
    output logic [NUM*BITS-1:0] frame_o,
    output logic                frame_valid_o,
    input  logic                frame_ready_i,
    output logic [CNT_W-1:0]    fill_cnt_o
);

    logic [1:0]       bank_full;
    logic             wr_sel;
    logic             rd_sel;
    logic [CNT_W-1:0] wr_cnt;

    logic [NUM*BITS-1:0] bank_frame [2];
    logic                accept;
    logic                take;
    logic                last;

    bank_state_e bank_state [2];

    assign ready_o       = !bank_full[wr_sel];
    assign frame_valid_o = bank_full[rd_sel];
    assign frame_o       = bank_frame[rd_sel];
    assign fill_cnt_o    = wr_cnt;

    assign accept = valid_i && ready_o && !flush_i;
    assign take   = frame_valid_o && frame_ready_i;
    assign last   = (wr_cnt == CNT_W'(NUM - 1));

    for (genvar b = 0; b < 2; b++) begin : g_bank
        frame_bank #(
            .NUM  (NUM),
            .BITS (BITS)
        ) u_bank (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .we_i    (accept && (wr_sel == 1'(b))),
            .idx_i   (wr_cnt),
            .data_i  (data_i),
            .frame_o (bank_frame[b])
        );
    end

    // Take and completion always hit different banks, so both may land.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bank_full <= 2'b00;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            wr_cnt    <= '0;
        end else begin
            if (flush_i) begin
                wr_cnt <= '0;
            end else if (accept) begin
                if (last) begin
                    bank_full[wr_sel] <= 1'b1;
                    wr_cnt            <= '0;
                    wr_sel            <= !wr_sel;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
            if (take) begin
                bank_full[rd_sel] <= 1'b0;
                rd_sel            <= !rd_sel;
            end
        end
    end

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_state[b] = EMPTY;
            if (bank_full[b]) begin
                bank_state[b] = FULL;
            end else if (wr_sel == 1'(b) && wr_cnt != '0) begin
                bank_state[b] = FILLING;
            end
        end
    end

    a_no_write_full : assert property (
        @(posedge clk_i) disable iff (rst_i)
        accept |-> bank_state[wr_sel] != FULL
    );

    a_take_full : assert property (
        @(posedge clk_i) disable iff (rst_i)
        take |-> bank_state[rd_sel] == FULL
    );

endmodule

// File: tb/tb_min_frame_loader.sv
// Self-checking bench for min_frame_loader against a queue-based model.
// Directed scenarios first, then a long randomized run.
module tb_min_frame_loader;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [3:0]  data_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic        flush_i = 1'b0;
    logic [39:0] frame_o;
    logic        frame_valid_o;
    logic        frame_ready_i = 1'b0;
    logic [3:0]  fill_cnt_o;

    int checks = 0;
    int errors = 0;
    int dut_takes = 0;

    logic [39:0] fq[$];
    logic [3:0]  pq[$];
    bit          zero_chk = 1'b1;

    always #5 clk_i = ~clk_i;

    min_frame_loader dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .data_i        (data_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .flush_i       (flush_i),
        .frame_o       (frame_o),
        .frame_valid_o (frame_valid_o),
        .frame_ready_i (frame_ready_i),
        .fill_cnt_o    (fill_cnt_o)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input bit v, input logic [3:0] d, input bit fl,
                        input bit fr, input bit rs);
        logic [39:0] f;
        bit m_ready;
        bit m_take;
        bit m_acc;
        @(negedge clk_i);
        valid_i = v;
        data_i = d;
        flush_i = fl;
        frame_ready_i = fr;
        rst_i = rs;
        #1;
        m_ready = fq.size() < 2;
        check("ready", 64'(ready_o), 64'(m_ready));
        check("fvalid", 64'(frame_valid_o), 64'(fq.size() > 0));
        check("fill", 64'(fill_cnt_o), 64'(pq.size()));
        if (fq.size() > 0) check("frame", 64'(frame_o), 64'(fq[0]));
        if (zero_chk) check("frame0", 64'(frame_o), 64'd0);
        if (frame_valid_o && frame_ready_i && !rs) dut_takes++;
        @(posedge clk_i);
        if (rs) begin
            fq.delete();
            pq.delete();
            zero_chk = 1'b1;
        end else begin
            zero_chk = 1'b0;
            m_take = fq.size() > 0 && fr;
            m_acc = v && m_ready && !fl;
            if (fl) pq.delete();
            if (m_take) void'(fq.pop_front());
            if (m_acc) begin
                pq.push_back(d);
                if (pq.size() == 10) begin
                    f = '0;
                    for (int k = 0; k < 10; k++) f[k*4 +: 4] = pq[k];
                    fq.push_back(f);
                    pq.delete();
                end
            end
        end
    endtask

    task automatic do_reset();
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [3:0] seq [10];
        seq = '{4'd9, 4'd3, 4'd7, 4'd1, 4'd4, 4'd8, 4'd2, 4'd6, 4'd5, 4'd0};
        repeat (2) @(posedge clk_i);
        do_reset();

        // single frame, consumer idle
        for (int i = 0; i < 10; i++) step(1'b1, seq[i], 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        check("single_s0", 64'(frame_o[3:0]), 64'd9);
        check("single_s9", 64'(frame_o[39:36]), 64'd0);

        // backpressure: both banks fill, then one take
        do_reset();
        for (int i = 0; i < 20; i++)
            step(1'b1, 4'($urandom_range(15)), 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        // streaming with an always-ready consumer
        do_reset();
        dut_takes = 0;
        for (int i = 0; i < 50; i++)
            step(1'b1, 4'(i % 16), 1'b0, 1'b1, 1'b0);
        step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        check("stream_takes", 64'(dut_takes), 64'd5);

        // flush drops partial samples and the flush-cycle sample
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd15, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        check("flush_frame", 64'(frame_o), 64'h5555555555);

        // reset mid-operation
        do_reset();
        for (int i = 0; i < 14; i++)
            step(1'b1, 4'($urandom_range(15)), 1'b0, 1'b0, 1'b0);
        do_reset();
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        // take and completion in the same cycle
        for (int i = 0; i < 19; i++)
            step(1'b1, 4'($urandom_range(15)), 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd7, 1'b0, 1'b1, 1'b0);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(3) != 0),
                 4'($urandom_range(15)),
                 1'($urandom_range(15) == 0),
                 1'($urandom_range(2) == 0),
                 1'($urandom_range(199) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
